// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin two-requester arbiter and sequencer for the word-only DM.
// Optional write trace enabled by defining DM_ARB_TRACE_EN.
module dm_arbiter #(
  parameter int MEM_WORDS = 3072,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [3:0]        be0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  output logic              ack0,
  output logic [31:0]       rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [3:0]        be1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic              ack1,
  output logic [31:0]       rdata1,
  output logic              err,
  output logic              busy,
  output logic              grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RMW_WR,
    RESP
  } state_e;

  localparam logic [ADDR_W-3:0] LIMIT = (ADDR_W-2)'(MEM_WORDS);

  state_e            state_q, state_d;
  logic              gid_q, gid_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-3:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic              errp_q, errp_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;

  logic              pick;
  logic              oor;
  logic              rd_load;
  logic [31:0]       rd_val;
  logic              unused_addr;

  // Byte offset bits are ignored: the memory is word-organised.
  assign unused_addr = ^{addr0[1:0], addr1[1:0]};

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gid_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      be_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      errp_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      last_q   <= last_d;
      we_q     <= we_d;
      be_q     <= be_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      errp_q   <= errp_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Arbitration, access sequencing and memory port drive.
  always_comb begin
    state_d   = state_q;
    gid_d     = gid_q;
    last_d    = last_q;
    we_d      = we_q;
    be_d      = be_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    merge_d   = merge_q;
    errp_d    = errp_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    rd_load   = 1'b0;
    rd_val    = '0;
    pick      = (req0 & req1) ? ~last_q : req1;
    oor       = (waddr_q >= LIMIT);

    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gid_d   = pick;
          we_d    = pick ? we1 : we0;
          be_d    = pick ? be1 : be0;
          waddr_d = pick ? addr1[ADDR_W-1:2] : addr0[ADDR_W-1:2];
          wdata_d = pick ? wdata1 : wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr = {waddr_q, 2'b00};
        rd_load  = 1'b1;
        state_d  = RESP;
        if (oor) begin
          errp_d = 1'b1;
        end else if (!we_q) begin
          rd_val = mem_rdata;
        end else if (be_q == 4'hF) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
        end else if (be_q != 4'h0) begin
          rd_load = 1'b0;
          merge_d = mem_rdata;
          state_d = RMW_WR;
        end
      end
      RMW_WR: begin
        mem_addr = {waddr_q, 2'b00};
        mem_we   = 1'b1;
        for (int i = 0; i < 4; i++) begin
          mem_wdata[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8]
                                        : merge_q[8*i +: 8];
        end
        rd_load = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        mem_addr = {waddr_q, 2'b00};
        last_d   = gid_q;
        errp_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rd_load) begin
      if (gid_q) rdata1_d = rd_val;
      else       rdata0_d = rd_val;
    end
  end

  assign ack0   = (state_q == RESP) & ~gid_q;
  assign ack1   = (state_q == RESP) & gid_q;
  assign err    = (state_q == RESP) & errp_q;
  assign busy   = (state_q != IDLE);
  assign grant  = gid_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

`ifdef DM_ARB_TRACE_EN
  // Log every memory write edge.
  always @(posedge clk) begin
    if (!reset && mem_we)
      $display("@%0d: *%h <= %h", gid_q, mem_addr, mem_wdata);
  end
`endif

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port word-organised data memory (`DM`).
- Requester 0 is the CPU load/store path; requester 1 is an auxiliary master (debug/DMA loader).
- Round-robin grant; one access at a time.
- Partial-word stores (sb/sh) become read-modify-write sequences, so the memory itself stays word-only.

Parameters:
- MEM_WORDS, 3072: number of 32-bit words behind the arbiter. Word index >= MEM_WORDS is out of range.
- ADDR_W, 32: byte-address width of requester and memory ports.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  requester 0 access request, held until ack0
we0  input  1  requester 0 write (1) / read (0)
be0  input  4  requester 0 byte enables, bit i = byte lane i (bits [8i+7:8i])
addr0  input  ADDR_W  requester 0 byte address (bits [1:0] ignored)
wdata0  input  32  requester 0 store data, lane-aligned
ack0  output  1  one-cycle completion pulse to requester 0
rdata0  output  32  requester 0 read data, valid while ack0=1
req1, we1, be1, addr1, wdata1, ack1, rdata1  same as above for requester 1
err  output  1  one-cycle pulse with ack when the access was out of range
busy  output  1  state != IDLE
grant  output  1  id of current/last granted requester
mem_addr  output  ADDR_W  byte address to DM, {latched_addr[ADDR_W-1:2],2'b00}
mem_we  output  1  DM write enable
mem_wdata  output  32  DM write data
mem_rdata  input  32  DM combinational read data for mem_addr

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; ack0/ack1/err/mem_we=0; rdata0/rdata1=0; mem_addr=0; mem_wdata=0; grant=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
- Requester contract: hold req, we, be, addr, wdata stable from assertion until the ack cycle. Req still high after ack is a new request.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both req: grant the one != last.
  - On grant, latch we/be/addr/wdata and the id into registers, then go to ACCESS.
- ACCESS: mem_addr driven from the latched address.
  - Out of range (addr[ADDR_W-1:2] >= MEM_WORDS): no write, rdata reg=0, err_pending=1, go to RESP.
  - Read: rdata reg <= mem_rdata, go to RESP. Reads return the full word; be is ignored.
  - Write, be=4'b1111: mem_we=1, mem_wdata=wdata, go to RESP.
  - Write, be=4'b0000: no mem_we, go to RESP.
  - Write, other be: merge reg <= mem_rdata, go to RMW_WR.
- RMW_WR: mem_we=1, mem_wdata lane i = be[i] ? wdata[lane i] : merge[lane i]. Go to RESP.
- RESP:
  - ack of the granted id=1 and rdata of that id=rdata reg; err=err_pending.
  - Other requester's ack=0.
  - last <= granted id; clear err_pending; go to IDLE.
- mem_we is combinational from state and is 0 in IDLE and RESP.
- mem_addr=0 in IDLE; it holds the latched address in ACCESS, RMW_WR and RESP.
- Latency, with req sampled in IDLE at edge 0:
  - Full-word/no-op access: ack high in cycle 2.
  - Partial write: ack high in cycle 3.
  - Best-case throughput: one access every 3 cycles (4 for RMW).
- Requests arriving while busy wait. The waiting requester wins the next IDLE arbitration whenever the other was just served, so there is no starvation.
- Reset in ACCESS or RMW_WR aborts immediately:
  - mem_we drops asynchronously; no write is committed unless the write edge already occurred.
  - No ack is issued; requesters must reissue.
- rdata0/rdata1 hold their value after ack until overwritten by that requester's next read or write completion.

Optional Feature:
- Macro DM_ARB_TRACE_EN.
- Defined: on every clock edge where mem_we=1 (and reset=0), simulation prints `@<grant id>: *<mem_addr hex> <= <mem_wdata hex>` via $display.
- Undefined: no display statements are compiled; behaviour is otherwise identical.

Test Plan:
1. Reset, then req0 full write addr0=0x10, be0=F, wdata0=0x12345678 → mem_we=1 at 0x10 in cycle 1; ack0 in cycle 2; err=0.
2. After 1, req0 read addr0=0x13 → mem_addr=0x10; ack0 in cycle 2 with rdata0=0x12345678.
3. After 1, req1 write be1=0010, addr1=0x10, wdata1=0x0000AB00 → RMW: memory becomes 0x1234AB78; ack1 in cycle 3.
4. req0 and req1 both asserted from IDLE after reset, held continuously → grants alternate 0,1,0,1; acks never in the same cycle.
5. req1 read addr1=4*MEM_WORDS (0x3000) → no mem_we; ack1 with rdata1=0 and err=1 for one cycle.
6. Assert reset asynchronously while in RMW_WR → mem_we drops immediately; memory word unchanged; state IDLE; no ack.
